uart_rx_oversampled: RTL

Serial receiver feeding the debug unit: samples the asynchronous `i_rx_data` line with a 16x oversampling baud tick, frames 8N1 characters (optionally 8E1), and presents each received byte with a one-cycle valid pulse. It sits between the board RX pin and the debug-unit command FSM, which consumes `o_data`/`o_rx_done` to select modes and load instruction words.

---
 rtl/uart_rx_oversampled.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 16x oversampled UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined)
module uart_rx_oversampled #(
  parameter int N_DATA   = 8,
  parameter int SB_TICK  = 16,
  parameter int BAUD_DIV = 326
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx_data,
  output logic [N_DATA-1:0] o_data,
  output logic              o_rx_done,
  output logic              o_frame_err,
  output logic              o_parity_err
);

  localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int S_W   = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam int N_W   = (N_DATA > 1) ? $clog2(N_DATA) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
  localparam logic [S_W-1:0]   TICK_MID = S_W'(SB_TICK / 2 - 1);
  localparam logic [S_W-1:0]   TICK_END = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]   BIT_LAST = N_W'(N_DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state_q, state_d;
  logic              rx_meta, rx_s;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [S_W-1:0]    s_cnt_q, s_cnt_d;
  logic [N_W-1:0]    n_cnt_q, n_cnt_d;
  logic [N_DATA-1:0] shreg_q, shreg_d;
  logic [N_DATA-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx_data;
      rx_s    <= rx_meta;
    end
  end

  // Free-running so the sampling phase is independent of the FSM state.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          s_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (s_cnt_q == TICK_MID) begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (!rx_s) begin
              state_d = S_DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (s_cnt_q == TICK_END) begin
            shreg_d = {rx_s, shreg_q[N_DATA-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + N_W'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (s_cnt_q == TICK_END) begin
            par_d   = rx_s;
            s_cnt_d = '0;
            state_d = S_STOP;
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (s_cnt_q == TICK_END) begin
            data_d = shreg_q;
            if (rx_s) begin
              done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_d  = (^shreg_q) ^ par_q;
`endif
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
